fifo_rd_sched: RTL and testbench

FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

---
 rtl/fifo_rd_sched.sv | 105 ++++++++++
 tb/tb_fifo_rd_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_sched.sv
// Read-side scheduler: grants FIFO read bursts to one of two consumers by round-robin
// and forwards each read word to the granted consumer one cycle after the read strobe.
module fifo_rd_sched #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic [1:0]        cons_req,
  input  logic [1:0]        cons_rdy,
  output logic [1:0]        gnt,
  output logic [1:0]        out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, LAST} state_t;

  localparam logic [2:0] BMAX = 3'(BURST_MAX);

  state_t            state, state_nxt;
  logic [2:0]        beat_cnt, beat_nxt;
  logic [1:0]        gnt_nxt;
  logic              rr_ptr, rr_nxt;
  logic              g;
  logic [1:0]        vld_p1;
  logic [DATA_W-1:0] data_p1;

  // rr_ptr is the last-served index; on a tie the other consumer wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] win;
    unique case (req)
      2'b11:   win = last ? 2'b01 : 2'b10;
      2'b10:   win = 2'b10;
      default: win = 2'b01;
    endcase
    return win;
  endfunction

  assign g    = gnt[1];
  assign busy = (state != IDLE);

  always_comb begin
    fifo_rd_en = (state == XFER) & ~fifo_empty & cons_req[g] & cons_rdy[g] & (beat_cnt < BMAX);
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    beat_nxt  = beat_cnt;
    rr_nxt    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (|cons_req) begin
          state_nxt = XFER;
          gnt_nxt   = rr_pick(cons_req, rr_ptr);
          beat_nxt  = 3'd0;
        end
      end
      XFER: begin
        if (fifo_rd_en) beat_nxt = beat_cnt + 3'd1;
        if ((fifo_rd_en && (beat_nxt == BMAX)) || fifo_empty || !cons_req[g])
          state_nxt = LAST;
      end
      LAST: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
        rr_nxt    = g;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      beat_cnt <= 3'd0;
      rr_ptr   <= 1'b1;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      beat_cnt <= beat_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

  // Stage p1: the FIFO word arrives one cycle after the strobe; steer it to the granted consumer.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) vld_p1 <= 2'b00;
    else         vld_p1 <= fifo_rd_en ? (g ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst)      data_p1 <= '0;
    else if (|vld_p1) data_p1 <= fifo_rd_data;
  end

  assign out_vld  = vld_p1;
  assign out_data = (|vld_p1) ? fifo_rd_data : data_p1;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched with a small FIFO model and a delivery logger.
module tb_fifo_rd_sched;

  logic       rd_clk = 1'b0;
  logic       rd_rst = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic [1:0] cons_req = 2'b00;
  logic [1:0] cons_rdy = 2'b00;
  logic [1:0] gnt;
  logic [1:0] out_vld;
  logic [7:0] out_data;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:63];
  int         wptr = 0;
  int         rptr = 0;
  int         rd_cnt = 0;
  logic [1:0] dq_cons [$];
  logic [7:0] dq_data [$];

  fifo_rd_sched #(.DATA_W(8), .BURST_MAX(4)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .cons_req(cons_req), .cons_rdy(cons_rdy), .gnt(gnt),
    .out_vld(out_vld), .out_data(out_data), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (rptr == wptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rptr % 64];
      rptr         <= rptr + 1;
    end
  end

  always @(negedge rd_clk) begin
    if (fifo_rd_en) rd_cnt = rd_cnt + 1;
    if (out_vld != 2'b00) begin
      dq_cons.push_back(out_vld);
      dq_data.push_back(out_data);
    end
  end

  task automatic tick;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wptr % 64] = base + 8'(i);
      wptr = wptr + 1;
    end
  endtask

  task automatic chk_deliv(input string nm, input int s, input int n, input logic [1:0] cons [],
                           input logic [7:0] base, input int d0);
    n_tests++;
    if (dq_data.size() - s !== n) begin
      n_fail++;
      $display("FAIL %s count: got %0d expected %0d", nm, dq_data.size() - s, n);
    end
    for (int i = 0; i < n; i++) begin
      if (s + i < dq_data.size()) begin
        n_tests++;
        if (dq_cons[s+i] !== cons[i] || dq_data[s+i] !== base + 8'(d0 + i)) begin
          n_fail++;
          $display("FAIL %s word%0d: got vld=%b data=%h expected vld=%b data=%h",
                   nm, i, dq_cons[s+i], dq_data[s+i], cons[i], base + 8'(d0 + i));
        end
      end
    end
  endtask

  task automatic test_reset;
    cons_req = 2'b11; cons_rdy = 2'b11;
    tick; tick;
    n_tests++;
    if ({gnt, out_vld, out_data, busy, fifo_rd_en} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b vld=%b data=%h busy=%b rd_en=%b expected all zero",
               gnt, out_vld, out_data, busy, fifo_rd_en);
    end
    cons_req = 2'b00;
    rd_rst = 1'b1;
    tick;
    n_tests++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got gnt=%b busy=%b expected 00/0", gnt, busy);
    end
  endtask

  task automatic test_rr_burst;
    int s, r0;
    logic [1:0] cons [];
    cons = new[10];
    for (int i = 0; i < 10; i++) cons[i] = (i < 4 || i >= 8) ? 2'b01 : 2'b10;
    load(10, 8'hA0);
    s = dq_data.size(); r0 = rd_cnt;
    cons_req = 2'b11; cons_rdy = 2'b11;
    repeat (30) tick;
    cons_req = 2'b00;
    repeat (4) tick;
    n_tests++;
    if (rd_cnt - r0 !== 10) begin
      n_fail++;
      $display("FAIL rr_burst rd_en count: got %0d expected 10", rd_cnt - r0);
    end
    chk_deliv("rr_burst", s, 10, cons, 8'hA0, 0);
  endtask

  task automatic test_empty_end;
    int s, r0;
    logic [1:0] cons [];
    cons = new[2];
    cons[0] = 2'b01; cons[1] = 2'b01;
    load(2, 8'hB0);
    s = dq_data.size(); r0 = rd_cnt;
    cons_req = 2'b01;
    repeat (8) tick;
    n_tests++;
    if (rd_cnt - r0 !== 2) begin
      n_fail++;
      $display("FAIL empty_end rd_en count: got %0d expected 2", rd_cnt - r0);
    end
    chk_deliv("empty_end", s, 2, cons, 8'hB0, 0);
    cons_req = 2'b00;
    repeat (4) tick;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_end idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_rdy_stall;
    int s, r0;
    logic [1:0] cons [];
    cons = new[4];
    for (int i = 0; i < 4; i++) cons[i] = 2'b01;
    load(4, 8'hC0);
    s = dq_data.size(); r0 = rd_cnt;
    cons_req = 2'b01; cons_rdy = 2'b01;
    tick;
    for (int cyc = 0; cyc < 10; cyc++) begin
      cons_rdy = (cyc >= 3 && cyc < 6) ? 2'b00 : 2'b01;
      #1;
      if (cyc >= 3 && cyc < 6) begin
        n_tests++;
        if (fifo_rd_en !== 1'b0 || gnt !== 2'b01) begin
          n_fail++;
          $display("FAIL rdy_stall cyc%0d: got rd_en=%b gnt=%b expected 0/01", cyc, fifo_rd_en, gnt);
        end
      end
      tick;
    end
    cons_req = 2'b00;
    repeat (3) tick;
    n_tests++;
    if (rd_cnt - r0 !== 4) begin
      n_fail++;
      $display("FAIL rdy_stall rd_en count: got %0d expected 4", rd_cnt - r0);
    end
    chk_deliv("rdy_stall", s, 4, cons, 8'hC0, 0);
    cons_rdy = 2'b11;
  endtask

  task automatic test_zero_beat;
    int r0;
    r0 = rd_cnt;
    cons_req = 2'b01;
    tick;
    n_tests++;
    if (gnt !== 2'b01 || busy !== 1'b1 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_beat xfer: got gnt=%b busy=%b rd_en=%b expected 01/1/0", gnt, busy, fifo_rd_en);
    end
    tick;
    n_tests++;
    if (gnt !== 2'b01 || busy !== 1'b1 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_beat last: got gnt=%b busy=%b rd_en=%b expected 01/1/0", gnt, busy, fifo_rd_en);
    end
    cons_req = 2'b00;
    tick;
    n_tests++;
    if (gnt !== 2'b00 || busy !== 1'b0 || out_vld !== 2'b00 || rd_cnt !== r0) begin
      n_fail++;
      $display("FAIL zero_beat idle: got gnt=%b busy=%b vld=%b reads=%0d expected 00/0/00/0",
               gnt, busy, out_vld, rd_cnt - r0);
    end
  endtask

  task automatic test_reset_mid;
    int s;
    logic [1:0] cons [];
    cons = new[3];
    for (int i = 0; i < 3; i++) cons[i] = 2'b01;
    load(4, 8'hD0);
    cons_req = 2'b11; cons_rdy = 2'b11;
    tick;
    n_tests++;
    if (gnt !== 2'b10 || fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid rr: got gnt=%b rd_en=%b expected 10/1", gnt, fifo_rd_en);
    end
    tick;
    s = dq_data.size();
    rd_rst = 1'b0;
    #1;
    n_tests++;
    if (gnt !== 2'b00 || out_vld !== 2'b00 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid clear: got gnt=%b vld=%b busy=%b rd_en=%b expected 00/00/0/0",
               gnt, out_vld, busy, fifo_rd_en);
    end
    tick;
    n_tests++;
    if (out_vld !== 2'b00 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid hold: got vld=%b gnt=%b expected 00/00", out_vld, gnt);
    end
    rd_rst = 1'b1;
    tick;
    n_tests++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid first_tie: got gnt=%b expected 01", gnt);
    end
    repeat (8) tick;
    cons_req = 2'b00;
    repeat (3) tick;
    chk_deliv("reset_mid", s, 3, cons, 8'hD0, 1);
  endtask

  task automatic test_req_drop;
    int s, r0;
    load(3, 8'hE0);
    s = dq_data.size(); r0 = rd_cnt;
    cons_req = 2'b10; cons_rdy = 2'b11;
    tick;
    n_tests++;
    if (gnt !== 2'b10 || fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL req_drop grant: got gnt=%b rd_en=%b expected 10/1", gnt, fifo_rd_en);
    end
    tick;
    n_tests++;
    if (fifo_rd_en !== 1'b1 || out_vld !== 2'b10 || out_data !== 8'hE0) begin
      n_fail++;
      $display("FAIL req_drop beat2: got rd_en=%b vld=%b data=%h expected 1/10/e0", fifo_rd_en, out_vld, out_data);
    end
    tick;
    cons_req = 2'b00;
    #1;
    n_tests++;
    if (fifo_rd_en !== 1'b0 || out_vld !== 2'b10 || out_data !== 8'hE1) begin
      n_fail++;
      $display("FAIL req_drop last_word: got rd_en=%b vld=%b data=%h expected 0/10/e1", fifo_rd_en, out_vld, out_data);
    end
    tick;
    n_tests++;
    if (out_vld !== 2'b00 || busy !== 1'b1 || gnt !== 2'b10 || out_data !== 8'hE1) begin
      n_fail++;
      $display("FAIL req_drop last_state: got vld=%b busy=%b gnt=%b data=%h expected 00/1/10/e1",
               out_vld, busy, gnt, out_data);
    end
    tick;
    n_tests++;
    if (busy !== 1'b0 || gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL req_drop idle: got busy=%b gnt=%b expected 0/00", busy, gnt);
    end
    n_tests++;
    if (rd_cnt - r0 !== 2 || dq_data.size() - s !== 2) begin
      n_fail++;
      $display("FAIL req_drop totals: got reads=%0d words=%0d expected 2/2", rd_cnt - r0, dq_data.size() - s);
    end
  endtask

  initial begin
    test_reset;
    test_rr_burst;
    test_empty_end;
    test_rdy_stall;
    test_zero_beat;
    test_reset_mid;
    test_req_drop;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
